// File: rtl/uart_pkg.sv
// Shared types and constants for the 16x-oversampled UART receive path.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DATA_W        = 8;
  localparam int ENTRY_W       = 11;
  localparam int TICKS_PER_BIT = 16;
  localparam int SAMPLE_MID    = 8;

  typedef struct packed {
    logic              brk;
    logic              ferr;
    logic              perr;
    logic [DATA_W-1:0] data;
  } rx_entry_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO; the head word is visible whenever not empty.
module uart_rx_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic             clk16x,
  input  logic             clrn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             overrun_drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             pop_ok;
  logic             wr_ok;

  // Extra pointer MSB separates the full and empty cases when the indices match.
  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_ok       = pop && !empty;
  assign wr_ok        = push && (!full || pop_ok);
  assign overrun_drop = push && full && !pop_ok;
  assign pop_data     = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk16x) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// UART receiver at 16x baud: line synchroniser, centred 3-sample majority voting,
// per-frame latched format, and an RX FIFO carrying per-entry error flags.
module uart_rx_cfg #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk16x,
  input  logic       clrn,
  input  logic       rxd,
  input  logic [1:0] cfg_bits,
  input  logic [1:0] cfg_parity,
  input  logic       cfg_stop2,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_perr,
  output logic       rd_ferr,
  output logic       rd_brk,
  output logic       rx_valid,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);
  import uart_pkg::*;

  localparam int            TW      = $clog2(TICKS_PER_BIT);
  localparam logic [TW-1:0] T_EARLY = TW'(SAMPLE_MID - 1);
  localparam logic [TW-1:0] T_MID   = TW'(SAMPLE_MID);
  localparam logic [TW-1:0] T_LATE  = TW'(SAMPLE_MID + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;
  logic                   prev_s;
  logic                   start_edge;

  rx_state_t         state;
  logic [TW-1:0]     tick;
  logic              s_early, s_mid;
  logic [2:0]        bit_cnt;
  logic [1:0]        bits_l, par_l;
  logic              stop2_l, stop_idx;
  logic [DATA_W-1:0] shift;
  logic              par_acc, ferr_acc, brk_acc;

  logic              decide, bit_val, par_en, last_stop, push;
  logic [1:0]        rjust;
  rx_entry_t         push_entry, head;
  logic [ENTRY_W-1:0] fifo_dout;
  logic              fifo_full, fifo_empty, fifo_drop;

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      sync_q <= '1;
      prev_s <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
      prev_s <= rxd_s;
    end
  end

  assign rxd_s      = sync_q[SYNC_STAGES-1];
  assign start_edge = !rxd_s && prev_s;

  // tick reads k mod 16 at edge D+k, so the voter window lands on ticks 7..9.
  assign decide    = (state != IDLE) && (tick == T_LATE);
  assign bit_val   = maj3(s_early, s_mid, rxd_s);
  assign par_en    = (par_l == PAR_EVEN) || (par_l == PAR_ODD);
  assign last_stop = (state == STOP) && (!stop2_l || stop_idx);
  assign push      = decide && last_stop;
  assign rjust     = 2'd3 - bits_l;

  always_comb begin
    push_entry      = '0;
    push_entry.data = shift >> rjust;
    push_entry.ferr = ferr_acc | ~bit_val;
    push_entry.brk  = stop_idx ? brk_acc : (brk_acc & ~bit_val);
    case (par_l)
      PAR_EVEN: push_entry.perr = par_acc;
      PAR_ODD:  push_entry.perr = ~par_acc;
      default:  push_entry.perr = 1'b0;
    endcase
  end

  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn) begin
      state    <= IDLE;
      tick     <= '0;
      s_early  <= 1'b1;
      s_mid    <= 1'b1;
      bit_cnt  <= '0;
      bits_l   <= '0;
      par_l    <= PAR_NONE;
      stop2_l  <= 1'b0;
      stop_idx <= 1'b0;
      shift    <= '0;
      par_acc  <= 1'b0;
      ferr_acc <= 1'b0;
      brk_acc  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_edge) begin
            state    <= START;
            tick     <= TW'(1);
            bits_l   <= cfg_bits;
            par_l    <= cfg_parity;
            stop2_l  <= cfg_stop2;
            stop_idx <= 1'b0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_acc  <= 1'b0;
            ferr_acc <= 1'b0;
            brk_acc  <= 1'b1;
          end
        end
        default: begin
          tick <= tick + TW'(1);
          if (tick == T_EARLY) s_early <= rxd_s;
          if (tick == T_MID)   s_mid   <= rxd_s;
          if (decide) begin
            case (state)
              START: state <= bit_val ? IDLE : DATA;
              DATA: begin
                shift   <= {bit_val, shift[DATA_W-1:1]};
                par_acc <= par_acc ^ bit_val;
                brk_acc <= brk_acc & ~bit_val;
                bit_cnt <= bit_cnt + 3'd1;
                // Last data bit index is 4 + cfg_bits.
                if (bit_cnt == {1'b1, bits_l}) state <= par_en ? PARITY : STOP;
              end
              PARITY: begin
                par_acc <= par_acc ^ bit_val;
                brk_acc <= brk_acc & ~bit_val;
                state   <= STOP;
              end
              STOP: begin
                if (last_stop) begin
                  state <= IDLE;
                end else begin
                  stop_idx <= 1'b1;
                  ferr_acc <= ~bit_val;
                  brk_acc  <= brk_acc & ~bit_val;
                end
              end
              default: state <= IDLE;
            endcase
          end
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk16x       (clk16x),
    .clrn         (clrn),
    .push         (push),
    .push_data    (push_entry),
    .pop          (rd_en),
    .pop_data     (fifo_dout),
    .full         (fifo_full),
    .empty        (fifo_empty),
    .overrun_drop (fifo_drop)
  );

  // A drop on the same cycle as clr_err must leave the flag set.
  always_ff @(posedge clk16x or negedge clrn) begin
    if (!clrn)                        overrun <= 1'b0;
    else if (fifo_drop && fifo_full)  overrun <= 1'b1;
    else if (clr_err)                 overrun <= 1'b0;
  end

  assign head     = rx_entry_t'(fifo_dout);
  assign rd_data  = head.data;
  assign rd_perr  = head.perr;
  assign rd_ferr  = head.ferr;
  assign rd_brk   = head.brk;
  assign rx_valid = !fifo_empty;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are modelled into exp_q as they are driven.
module tb_uart_rx_cfg;

  localparam int DEPTH = 8;

  logic       clk16x = 1'b0;
  logic       clrn = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] cfg_bits = 2'b11;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2 = 1'b0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_perr, rd_ferr, rd_brk, rx_valid, overrun, busy;

  uart_rx_cfg #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk16x     (clk16x),
    .clrn       (clrn),
    .rxd        (rxd),
    .cfg_bits   (cfg_bits),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_perr    (rd_perr),
    .rd_ferr    (rd_ferr),
    .rd_brk     (rd_brk),
    .rx_valid   (rx_valid),
    .overrun    (overrun),
    .clr_err    (clr_err),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk16x = ~clk16x;

  int cyc = 0;
  always @(posedge clk16x) cyc <= cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad = 0;
  logic [10:0] exp_q[$];
  int last_d = 0;

  // edge monitor, sampled on the falling edge
  int   rv_rise = -1, busy_rise = -1, busy_fall = -1;
  logic rv_prev = 1'b0, busy_prev = 1'b0;
  always @(negedge clk16x) begin
    if (rx_valid && !rv_prev) rv_rise = cyc;
    if (busy && !busy_prev)   busy_rise = cyc;
    if (!busy && busy_prev)   busy_fall = cyc;
    rv_prev   = rx_valid;
    busy_prev = busy;
  end

  function automatic logic [10:0] model(input logic [7:0] data, input int nb, input logic [1:0] par,
                                        input logic st2, input logic flip, input logic s1, input logic s2);
    logic [7:0] md;
    logic paren, pbit, perr, ferr, brk;
    md    = data & 8'((1 << nb) - 1);
    paren = (par == 2'b01) || (par == 2'b10);
    pbit  = ((par == 2'b10) ? ~(^md) : ^md) ^ flip;
    perr  = paren && flip;
    ferr  = !s1 || (st2 && !s2);
    brk   = (md == 8'h00) && (!paren || !pbit) && !s1;
    return {brk, ferr, perr, md};
  endfunction

  // driver: one frame, 16 clocks per bit; optional rd_en pulse at edge D+pop_off+1
  task automatic send_frame(input logic [7:0] data, input int nb, input logic [1:0] par, input logic st2,
                            input logic flip, input logic s1, input logic s2, input int pop_off);
    logic [12:0] fb;
    logic [7:0]  md;
    logic        pbit;
    int          n, d;
    md   = data & 8'((1 << nb) - 1);
    pbit = ((par == 2'b10) ? ~(^md) : ^md) ^ flip;
    fb   = '0;
    for (int j = 0; j < nb; j++) fb[1+j] = md[j];
    n = 1 + nb;
    if (par == 2'b01 || par == 2'b10) begin fb[n] = pbit; n++; end
    fb[n] = s1; n++;
    if (st2) begin fb[n] = s2; n++; end
    d = 0;
    for (int i = 0; i < n * 16; i++) begin
      @(negedge clk16x);
      rxd = fb[i/16];
      if (i == 0) d = cyc + 3;
      if (pop_off >= 0) rd_en = (cyc == d + pop_off);
    end
    @(negedge clk16x);
    rxd = 1'b1;
    rd_en = 1'b0;
    repeat (4) @(negedge clk16x);
    last_d = d;
  endtask

  task automatic frame(input logic [7:0] data, input int nb, input logic [1:0] par, input logic st2,
                       input logic flip, input logic s1, input logic s2, input bit expect_push);
    @(negedge clk16x);
    cfg_bits = 2'(nb - 5);
    cfg_parity = par;
    cfg_stop2 = st2;
    if (expect_push) exp_q.push_back(model(data, nb, par, st2, flip, s1, s2));
    send_frame(data, nb, par, st2, flip, s1, s2, -1);
  endtask

  // scoreboard: pop one expected entry and compare against the head
  task automatic read_one();
    logic [10:0] exp, act;
    int w;
    w = 0;
    while (!rx_valid && w < 400) begin @(negedge clk16x); w++; end
    total++;
    if (!rx_valid) begin
      $display("FAIL read_wait: rx_valid=%b want 1 (queue left %0d)", rx_valid, exp_q.size());
      bad++;
      void'(exp_q.pop_front());
    end else begin
      exp = exp_q.pop_front();
      act = {rd_brk, rd_ferr, rd_perr, rd_data};
      total++;
      if (act !== exp) begin
        $display("FAIL entry: got brk/ferr/perr/data=%h want %h", act, exp);
        bad++;
      end
      rd_en = 1'b1;
      @(negedge clk16x);
      rd_en = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    while (exp_q.size() > 0) read_one();
    total++;
    if (rx_valid !== 1'b0) begin
      $display("FAIL %s_empty: rx_valid=%b want 0", name, rx_valid);
      bad++;
    end
  endtask

  task automatic test_reset();
    clrn = 1'b0;
    rxd = 1'b1;
    repeat (3) @(negedge clk16x);
    total++;
    if ({rx_valid, busy, overrun} !== 3'b000) begin
      $display("FAIL reset_flags: valid/busy/overrun=%b want 000", {rx_valid, busy, overrun});
      bad++;
    end
    total++;
    if ({rd_brk, rd_ferr, rd_perr, rd_data} !== 11'h000) begin
      $display("FAIL reset_rd: got %h want 000", {rd_brk, rd_ferr, rd_perr, rd_data});
      bad++;
    end
    clrn = 1'b1;
    repeat (8) @(negedge clk16x);
    total++;
    if ({rx_valid, busy} !== 2'b00) begin
      $display("FAIL reset_release: valid/busy=%b want 00", {rx_valid, busy});
      bad++;
    end
  endtask

  task automatic test_8n1();
    rv_rise = -1; busy_rise = -1; busy_fall = -1;
    frame(8'hA5, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    total++;
    if (rv_rise != last_d + 153) begin
      $display("FAIL 8n1_valid_rise: edge D+%0d want D+153", rv_rise - last_d);
      bad++;
    end
    total++;
    if (busy_rise != last_d) begin
      $display("FAIL 8n1_busy_rise: edge D+%0d want D+0", busy_rise - last_d);
      bad++;
    end
    total++;
    if (busy_fall != last_d + 153) begin
      $display("FAIL 8n1_busy_fall: edge D+%0d want D+153", busy_fall - last_d);
      bad++;
    end
    drain("8n1");
  endtask

  task automatic test_random_cfg();
    for (int i = 0; i < 6; i++) begin
      frame(8'($urandom_range(0, 255)), $urandom_range(5, 8), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1);
      drain("random");
    end
  endtask

  task automatic test_7e2();
    frame(8'h35, 7, 2'b01, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    frame(8'h35, 7, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    frame(8'h35, 7, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    frame(8'h4C, 6, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    drain("7e2");
  endtask

  task automatic test_false_start();
    int d;
    busy_rise = -1; busy_fall = -1;
    @(negedge clk16x);
    rxd = 1'b0;
    d = cyc + 3;
    repeat (5) @(negedge clk16x);
    rxd = 1'b1;
    repeat (40) @(negedge clk16x);
    total++;
    if (busy_rise != d) begin
      $display("FAIL false_busy_rise: edge D+%0d want D+0", busy_rise - d);
      bad++;
    end
    total++;
    if (busy_fall != d + 9) begin
      $display("FAIL false_busy_fall: edge D+%0d want D+9", busy_fall - d);
      bad++;
    end
    total++;
    if (rx_valid !== 1'b0) begin
      $display("FAIL false_push: rx_valid=%b want 0", rx_valid);
      bad++;
    end
  endtask

  task automatic test_break();
    int d;
    @(negedge clk16x);
    cfg_bits = 2'b11; cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    exp_q.push_back(11'b110_0000_0000);
    busy_fall = -1;
    @(negedge clk16x);
    rxd = 1'b0;
    d = cyc + 3;
    repeat (40 * 16) @(negedge clk16x);
    total++;
    if ({busy, rx_valid} !== 2'b01) begin
      $display("FAIL break_held: busy/valid=%b want 01", {busy, rx_valid});
      bad++;
    end
    total++;
    if (busy_fall != d + 153) begin
      $display("FAIL break_push: edge D+%0d want D+153", busy_fall - d);
      bad++;
    end
    rxd = 1'b1;
    repeat (32) @(negedge clk16x);
    drain("break");
    frame(8'h3C, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drain("break_recover");
  endtask

  task automatic test_overrun();
    logic [7:0] data;
    for (int i = 0; i <= DEPTH; i++) begin
      data = 8'($urandom_range(0, 255));
      if (i == DEPTH) begin
        total++;
        if (overrun !== 1'b0) begin
          $display("FAIL overrun_early: overrun=%b want 0", overrun);
          bad++;
        end
      end
      frame(data, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, i < DEPTH);
    end
    total++;
    if (overrun !== 1'b1) begin
      $display("FAIL overrun_set: overrun=%b want 1", overrun);
      bad++;
    end
    clr_err = 1'b1;
    @(negedge clk16x);
    clr_err = 1'b0;
    total++;
    if (overrun !== 1'b0) begin
      $display("FAIL overrun_clear: overrun=%b want 0", overrun);
      bad++;
    end
    drain("overrun");
  endtask

  task automatic test_reset_mid();
    frame(8'h5A, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    @(negedge clk16x);
    for (int i = 0; i < 4 * 16 + 8; i++) begin
      rxd = (i < 16) ? 1'b0 : ((i / 16) % 2 == 1);
      @(negedge clk16x);
    end
    total++;
    if (busy !== 1'b1) begin
      $display("FAIL midreset_busy: busy=%b want 1", busy);
      bad++;
    end
    clrn = 1'b0;
    rxd = 1'b1;
    #1;
    total++;
    if ({busy, rx_valid} !== 2'b00) begin
      $display("FAIL midreset_async: busy/valid=%b want 00", {busy, rx_valid});
      bad++;
    end
    exp_q.delete();
    repeat (3) @(negedge clk16x);
    clrn = 1'b1;
    repeat (200) @(negedge clk16x);
    total++;
    if ({busy, rx_valid} !== 2'b00) begin
      $display("FAIL midreset_after: busy/valid=%b want 00", {busy, rx_valid});
      bad++;
    end
  endtask

  task automatic test_full_pushpop();
    logic [10:0] exp;
    logic [7:0]  data;
    for (int i = 0; i < DEPTH; i++) frame(8'($urandom_range(0, 255)), 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    exp = exp_q.pop_front();
    total++;
    if ({rd_brk, rd_ferr, rd_perr, rd_data} !== exp) begin
      $display("FAIL full_head: got %h want %h", {rd_brk, rd_ferr, rd_perr, rd_data}, exp);
      bad++;
    end
    data = 8'($urandom_range(0, 255));
    exp_q.push_back(model(data, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
    send_frame(data, 8, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 152);
    total++;
    if ({overrun, rx_valid} !== 2'b01) begin
      $display("FAIL full_pushpop: overrun/valid=%b want 01", {overrun, rx_valid});
      bad++;
    end
    drain("full_pushpop");
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_random_cfg();
    test_7e2();
    test_false_start();
    test_break();
    test_overrun();
    test_reset_mid();
    test_full_pushpop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
